gelato_ram_arbiter: RTL and testbench
=====================================

// Module: gelato_ram_arbiter
// PURPOSE
//   Shares the single Gelato RAM port (the fake_ram side in simulation) among NUM_REQ requesters,
//   e.g. instruction fetch and per-warp load/store units.
//   Grants round-robin and keeps one RAM transaction in flight at a time.
//   Returns each response to its owner and recovers from a stalled RAM with a timeout error.
// PARAMETERS
//   NUM_REQ     4    number of requesters (>=2); OWN_W = $clog2(NUM_REQ)
//   ADDR_WIDTH  32   byte address width
//   DATA_WIDTH  32   data word width
//   TIMEOUT     255  max cycles spent in WAIT before an error response (>=1); counter width $clog2(TIMEOUT+1)
// PORTS
//   clk            in   1                   clock, all state on rising edge
//   rst            in   1                   synchronous reset, active-high
//   rdy            in   1                   global enable; 0 = freeze all state
//   req_valid      in   NUM_REQ             per-requester request valid
//   req_ready      out  NUM_REQ             one-hot grant/accept, combinational
//   req_we         in   NUM_REQ             1 = write, 0 = read
//   req_addr       in   NUM_REQ*ADDR_WIDTH  packed addresses, slot i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   req_wdata      in   NUM_REQ*DATA_WIDTH  packed write data, slot i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rsp_valid      out  NUM_REQ             one-hot response pulse, registered
//   rsp_err        out  1                   response is a timeout error, valid with rsp_valid
//   rsp_data       out  DATA_WIDTH          read data (0 for writes/errors), shared bus
//   ram_valid      out  1                   RAM request valid
//   ram_ready      in   1                   RAM accepts request
//   ram_we         out  1                   RAM write enable
//   ram_addr       out  ADDR_WIDTH          RAM address
//   ram_wdata      out  DATA_WIDTH          RAM write data
//   ram_rsp_valid  in   1                   RAM completion (reads and writes both acknowledged)
//   ram_rsp_data   in   DATA_WIDTH          RAM read data
//   busy           out  1                   state != IDLE
// BEHAVIOUR
//   Reset: state=IDLE, rr_ptr=0, timer=0; all registered outputs 0; req_ready=0 while rst=1.
//   rdy=0: no state or register update; req_ready forced 0. Registered outputs hold their value;
//     consumers sample rsp_valid only when rdy=1.
//   FSM: IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE: grant = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
//     req_ready[grant]=1 in the same cycle. Latch we/addr/wdata/owner=grant; go to ISSUE.
//     req_ready is 0 in every other state; requesters hold req_* stable until accepted.
//   ISSUE: ram_valid=1 with ram_we/addr/wdata driven from the latched fields (registered outputs).
//     On ram_ready=1: ram_valid->0, timer=0, go to WAIT.
//   WAIT: on ram_rsp_valid=1: next cycle rsp_valid[owner]=1, rsp_err=0,
//     rsp_data=ram_rsp_data (read) or 0 (write); rr_ptr=(owner+1)%NUM_REQ; go to IDLE.
//     Else timer++. If timer reaches TIMEOUT: same exit with rsp_err=1, rsp_data=0.
//   Same-cycle ram_rsp_valid and timeout: the response wins, rsp_err=0.
//   rsp_valid and rsp_err are one-cycle pulses; they clear on the next enabled cycle.
//   ram_rsp_valid in IDLE or ISSUE is ignored (spurious); no state change.
//   Latency (no stalls): accepted at T; ram_valid at T+1; WAIT at T+2.
//     ram_rsp_valid at T+2 -> rsp_valid at T+3 and IDLE at T+3, next grant possible at T+3.
//   Fairness: a continuously requesting agent waits at most NUM_REQ-1 transactions.
//   rr_ptr wraps from NUM_REQ-1 to 0.
//   Reset mid-transaction: transaction dropped, no rsp_valid issued, ram_valid drops next edge.
// TESTING
//   1 rst held 3 cycles, then idle: all outputs 0, busy=0, req_ready=0.
//   2 req0 read 0x100, RAM ready at once, returns 0xDEADBEEF one cycle later:
//     req_ready[0] at T, ram_valid at T+1, rsp_valid=4'b0001 with data 0xDEADBEEF at T+3.
//   3 all 4 requesters valid continuously: grant order 0,1,2,3,0 (reads and writes mixed),
//     each rsp_valid pulsed exactly once per grant.
//   4 ram_ready held low 5 cycles in ISSUE: ram_valid/addr stable throughout, no req_ready, busy=1.
//   5 TIMEOUT=8, RAM never responds: rsp_valid[owner]=1 with rsp_err=1, rsp_data=0,
//     exactly 9 cycles after entering WAIT; next request is granted normally.
//   6 rdy=0 for 4 cycles in WAIT while ram_rsp_valid is pulsed and dropped: nothing latched.
//     rst asserted in WAIT: state IDLE, no response, rr_ptr=0.

Source files
------------

// File: rtl/gelato_ram_arbiter.sv
// Round-robin arbiter sharing one RAM port among NUM_REQ requesters.
// One transaction in flight; responses are routed back to the owner.
// A stalled RAM is recovered with a timeout error response.
module gelato_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic                          rsp_err,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          ram_valid,
  input  logic                          ram_ready,
  output logic                          ram_we,
  output logic [ADDR_WIDTH-1:0]         ram_addr,
  output logic [DATA_WIDTH-1:0]         ram_wdata,
  input  logic                          ram_rsp_valid,
  input  logic [DATA_WIDTH-1:0]         ram_rsp_data,
  output logic                          busy
);

  localparam int unsigned OwnW = $clog2(NUM_REQ);
  localparam int unsigned TmrW = $clog2(TIMEOUT + 1);
  localparam logic [OwnW:0] NumReqW = (OwnW + 1)'(NUM_REQ);
  localparam logic [OwnW-1:0] LastIdx = OwnW'(NUM_REQ - 1);
  localparam logic [TmrW-1:0] TimeoutW = TmrW'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e                state_q, state_d;
  logic [OwnW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [OwnW-1:0]       owner_q, owner_d;
  logic [TmrW-1:0]       timer_q, timer_d;
  logic                  ram_valid_q, ram_valid_d;
  logic                  ram_we_q, ram_we_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q, ram_wdata_d;
  logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
  logic                  rsp_err_q, rsp_err_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;

  logic                  grant_valid;
  logic [OwnW-1:0]       grant_idx;
  logic [OwnW-1:0]       owner_next;

  // Round-robin search starting at rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    logic [OwnW:0] sum;
    grant_valid = 1'b0;
    grant_idx   = '0;
    sum         = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr_q} + (OwnW + 1)'(k);
      if (sum >= NumReqW) begin
        sum = sum - NumReqW;
      end
      if (!grant_valid && req_valid[sum[OwnW-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = sum[OwnW-1:0];
      end
    end
  end

  assign owner_next = (owner_q == LastIdx) ? '0 : owner_q + OwnW'(1);

  // Next-state logic for the transaction FSM and its registered outputs.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    timer_d     = timer_q;
    ram_valid_d = ram_valid_q;
    ram_we_d    = ram_we_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    rsp_valid_d = '0;
    rsp_err_d   = 1'b0;
    rsp_data_d  = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_valid) begin
          owner_d     = grant_idx;
          ram_valid_d = 1'b1;
          ram_we_d    = req_we[grant_idx];
          ram_addr_d  = req_addr[grant_idx*ADDR_WIDTH +: ADDR_WIDTH];
          ram_wdata_d = req_wdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
          state_d     = StIssue;
        end
      end
      StIssue: begin
        if (ram_ready) begin
          ram_valid_d = 1'b0;
          timer_d     = '0;
          state_d     = StWait;
        end
      end
      StWait: begin
        // A real response beats a coincident timeout.
        if (ram_rsp_valid) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_data_d           = ram_we_q ? '0 : ram_rsp_data;
          rr_ptr_d             = owner_next;
          state_d              = StIdle;
        end else if (timer_q == TimeoutW) begin
          rsp_valid_d[owner_q] = 1'b1;
          rsp_err_d            = 1'b1;
          rr_ptr_d             = owner_next;
          state_d              = StIdle;
        end else begin
          timer_d = timer_q + TmrW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Combinational one-hot accept, suppressed in reset and while frozen.
  always_comb begin
    req_ready = '0;
    if (state_q == StIdle && grant_valid && rdy && !rst) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  // State registers: synchronous reset, rdy gates every update.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      timer_q     <= '0;
      ram_valid_q <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      rsp_valid_q <= '0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      timer_q     <= timer_d;
      ram_valid_q <= ram_valid_d;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign ram_valid = ram_valid_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_gelato_ram_arbiter.sv
// Bench for gelato_ram_arbiter: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a transaction-level model.
module tb_gelato_ram_arbiter;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic            clk = 1'b0;
  logic            rst, rdy;
  logic [N-1:0]    req_valid, req_ready, req_we, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic            rsp_err, ram_valid, ram_ready, ram_we, ram_rsp_valid, busy;
  logic [DW-1:0]   rsp_data, ram_wdata, ram_rsp_data;
  logic [AW-1:0]   ram_addr;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  gelato_ram_arbiter #(
    .NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .ram_valid(ram_valid), .ram_ready(ram_ready), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rsp_valid(ram_rsp_valid), .ram_rsp_data(ram_rsp_data),
    .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // One outstanding transaction: owner, whether the RAM has taken it yet,
  // and how many enabled cycles it has waited for completion.
  bit            has_txn_m  = 0;
  bit            at_ram_m   = 0;
  int            owner_m    = 0;
  int            waited_m   = 0;
  int            ptr_m      = 0;
  logic          we_m       = 0;
  logic [AW-1:0] addr_m     = 0;
  logic [DW-1:0] wdata_m    = 0;
  logic [N-1:0]  xrsp_valid = 0;
  logic          xrsp_err   = 0;
  logic [DW-1:0] xrsp_data  = 0;

  always @(negedge clk) begin
    logic [N-1:0] xready;
    int g;
    int idx;
    xready = '0;
    g      = -1;
    if (!rst && rdy && !has_txn_m) begin
      for (int k = 0; k < N; k++) begin
        idx = (ptr_m + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    if (g >= 0) xready[g] = 1'b1;

    chk("m_req_ready", req_ready, xready);
    chk("m_busy", busy, has_txn_m);
    chk("m_ram_valid", ram_valid, at_ram_m);
    if (at_ram_m) begin
      chk("m_ram_we", ram_we, we_m);
      chk("m_ram_addr", ram_addr, addr_m);
      chk("m_ram_wdata", ram_wdata, wdata_m);
    end
    chk("m_rsp_valid", rsp_valid, xrsp_valid);
    chk("m_rsp_err", rsp_err, xrsp_err);
    chk("m_rsp_data", rsp_data, xrsp_data);

    // Advance to what the coming edge should produce.
    if (rst) begin
      has_txn_m  = 0;
      at_ram_m   = 0;
      waited_m   = 0;
      ptr_m      = 0;
      xrsp_valid = '0;
      xrsp_err   = 0;
      xrsp_data  = '0;
    end else if (rdy) begin
      xrsp_valid = '0;
      xrsp_err   = 0;
      xrsp_data  = '0;
      if (g >= 0) begin
        has_txn_m = 1;
        at_ram_m  = 1;
        owner_m   = g;
        we_m      = req_we[g];
        addr_m    = req_addr[g*AW +: AW];
        wdata_m   = req_wdata[g*DW +: DW];
      end else if (has_txn_m && at_ram_m) begin
        if (ram_ready) begin
          at_ram_m = 0;
          waited_m = 0;
        end
      end else if (has_txn_m) begin
        if (ram_rsp_valid || waited_m == TO) begin
          xrsp_valid[owner_m] = 1'b1;
          xrsp_err            = !ram_rsp_valid;
          xrsp_data           = (ram_rsp_valid && !we_m) ? ram_rsp_data : '0;
          has_txn_m           = 0;
          ptr_m               = (owner_m + 1) % N;
        end else begin
          waited_m++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic look();
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] d);
    req_valid[i]          = 1'b1;
    req_we[i]             = we;
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic drain(input int cycles);
    req_valid     = '0;
    ram_ready     = 1'b1;
    ram_rsp_valid = 1'b1;
    repeat (cycles) step();
    ram_rsp_valid = 1'b0;
  endtask

  int           order[5];
  int           exp_order[5] = '{0, 1, 2, 3, 0};
  int           ng, rcnt, lat;
  bit           found;
  logic [N-1:0] acc;

  initial begin
    rst = 1'b1; rdy = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ram_ready = 1'b0; ram_rsp_valid = 1'b0; ram_rsp_data = '0;

    // Reset held 3 cycles; a request during reset is never accepted.
    set_req(0, 1'b0, 32'h10, 32'h0);
    look();
    chk("rst_req_ready", req_ready, 4'b0000);
    step();
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
    look();
    chk("idle_busy", busy, 1'b0);
    chk("idle_req_ready", req_ready, 4'b0000);
    chk("idle_ram_valid", ram_valid, 1'b0);
    chk("idle_ram_addr", ram_addr, 32'h0);
    chk("idle_rsp_valid", rsp_valid, 4'b0000);
    chk("idle_rsp_err", rsp_err, 1'b0);
    chk("idle_rsp_data", rsp_data, 32'h0);
    step();

    // Single read, RAM immediately ready, data one cycle later.
    set_req(0, 1'b0, 32'h100, 32'h0);
    ram_ready = 1'b1;
    look();
    chk("t2_grant", req_ready, 4'b0001);
    step();
    req_valid = '0;
    look();
    chk("t2_ram_valid", ram_valid, 1'b1);
    chk("t2_ram_addr", ram_addr, 32'h100);
    step();
    ram_rsp_valid = 1'b1;
    ram_rsp_data  = 32'hDEADBEEF;
    look();
    chk("t2_busy_wait", busy, 1'b1);
    step();
    ram_rsp_valid = 1'b0;
    look();
    chk("t2_rsp_valid", rsp_valid, 4'b0001);
    chk("t2_rsp_data", rsp_data, 32'hDEADBEEF);
    chk("t2_rsp_err", rsp_err, 1'b0);
    step();

    // All requesters continuously valid from a fresh reset: rotation 0,1,2,3,0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'(i % 2), 32'h1000 + 32'(i * 16), 32'hA0 + 32'(i));
    ram_ready     = 1'b1;
    ram_rsp_valid = 1'b1;
    ram_rsp_data  = 32'hCAFE0000;
    ng   = 0;
    rcnt = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      look();
      acc = req_ready;
      if (rsp_valid != 0) rcnt++;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && ng < 5) begin
          order[ng] = i;
          ng++;
        end
      end
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) set_req(i, ~req_we[i], req_addr[i*AW +: AW] + 32'h4, 32'(c));
      end
      ram_rsp_data = ram_rsp_data + 32'h1;
    end
    req_valid = '0;
    repeat (8) begin
      look();
      if (rsp_valid != 0) rcnt++;
      step();
    end
    ram_rsp_valid = 1'b0;
    chk("t3_grant_count", ng, 5);
    for (int k = 0; k < 5; k++) chk("t3_order", order[k], exp_order[k]);
    chk("t3_rsp_count", rcnt, 5);

    // RAM stalls 5 cycles in ISSUE; another requester must not be accepted.
    ram_ready = 1'b0;
    set_req(2, 1'b1, 32'h2A0, 32'h55AA);
    look();
    chk("t4_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    set_req(1, 1'b0, 32'h140, 32'h0);
    repeat (5) begin
      look();
      chk("t4_ram_valid", ram_valid, 1'b1);
      chk("t4_ram_addr", ram_addr, 32'h2A0);
      chk("t4_no_ready", req_ready, 4'b0000);
      chk("t4_busy", busy, 1'b1);
      step();
    end
    ram_ready = 1'b1;
    look();
    step();
    ram_ready     = 1'b0;
    ram_rsp_valid = 1'b1;
    ram_rsp_data  = 32'h12345678;
    look();
    step();
    ram_rsp_valid = 1'b0;
    look();
    chk("t4_rsp_valid", rsp_valid, 4'b0100);
    chk("t4_rsp_write_data", rsp_data, 32'h0);
    chk("t4_next_grant", req_ready, 4'b0010);
    step();
    drain(6);

    // RAM never answers: timeout error 9 cycles after WAIT entry (11 after accept).
    ram_ready = 1'b1;
    set_req(3, 1'b0, 32'h3C0, 32'h0);
    look();
    chk("t5_grant", req_ready, 4'b1000);
    step();
    req_valid = '0;
    found = 0;
    lat   = -1;
    for (int k = 1; k <= 30 && !found; k++) begin
      look();
      if (rsp_valid != 0) begin
        found = 1;
        lat   = k;
        chk("t5_rsp_owner", rsp_valid, 4'b1000);
        chk("t5_rsp_err", rsp_err, 1'b1);
        chk("t5_rsp_data", rsp_data, 32'h0);
      end
      step();
    end
    chk("t5_latency", lat, 11);
    set_req(0, 1'b0, 32'h40, 32'h0);
    ram_rsp_valid = 1'b1;
    ram_rsp_data  = 32'h0BADF00D;
    look();
    chk("t5_next_grant", req_ready, 4'b0001);
    step();
    drain(6);

    // Freeze in WAIT while a response pulses; then reset mid-transaction.
    set_req(2, 1'b0, 32'h2C0, 32'h0);
    look();
    chk("t6_grant", req_ready, 4'b0100);
    step();
    req_valid = '0;
    look();
    step();
    look();
    step();
    rdy           = 1'b0;
    ram_rsp_valid = 1'b1;
    ram_rsp_data  = 32'hFFFF0000;
    look();
    step();
    ram_rsp_valid = 1'b0;
    repeat (3) begin
      look();
      step();
    end
    rdy = 1'b1;
    look();
    chk("t6_no_rsp", rsp_valid, 4'b0000);
    chk("t6_still_busy", busy, 1'b1);
    step();
    rst = 1'b1;
    look();
    step();
    rst = 1'b0;
    look();
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_rsp", rsp_valid, 4'b0000);
    step();
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 32'h800 + 32'(i * 4), 32'h0);
    look();
    chk("t6_ptr_reset", req_ready, 4'b0001);
    step();
    drain(6);

    // Randomized traffic, checked by the model every cycle.
    acc = '0;
    repeat (3000) begin
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          if ($urandom % 10 < 6) set_req(i, 1'($urandom % 2), $urandom, $urandom);
          else req_valid[i] = 1'b0;
        end else if (!req_valid[i] && ($urandom % 4 == 0)) begin
          set_req(i, 1'($urandom % 2), $urandom, $urandom);
        end
      end
      ram_ready     = ($urandom % 3) != 0;
      ram_rsp_valid = ($urandom % 4) == 0;
      ram_rsp_data  = $urandom;
      rdy           = ($urandom % 10) != 0;
      rst           = ($urandom % 150) == 0;
      look();
      acc = req_ready;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
